// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
//
// Collects the parallel results of one layer's neurons and sends them to the
// next layer as a stream, one word per cycle, in neuron-index order (0 first).
// There are two banks. A capture bank fills from the neuron valid pulses while
// a shift bank drains. This lets layer N+1 take the stream for one sample while
// layer N computes the next sample.
//
// Parameters:
//   NUM_NEURONS  neurons in the upstream layer (>= 2)
//   DATA_WIDTH   width of each neuron output word, signed two's complement
//   IDX_WIDTH    width of the index counter
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   neuronOut_i    neuron j's word at [j*DATA_WIDTH +: DATA_WIDTH]
//   neuronValid_i  bit j: single-cycle valid pulse from neuron j
//   out_o          serialized word (registered)
//   outValid_or    out_o is valid this cycle (next layer's myInputValid_i)
//   outIdx_o       index of the neuron whose word is on out_o
//   done_o         high together with the last word of a frame
//   busy_o         shift bank is draining
//   overrun_o      sticky: a neuron word was dropped
//
// Build option:
//   LAYER_SERIALIZER_RELU_EN  when defined, every word driven onto out_o goes
//                             through a ReLU (negative -> 0). The captured data
//                             stays unchanged.
// -----------------------------------------------------------------------------
module layer_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuronOut_i,
    input  logic [NUM_NEURONS-1:0]            neuronValid_i,
    output logic [DATA_WIDTH-1:0]             out_o,
    output logic                              outValid_or,
    output logic [IDX_WIDTH-1:0]              outIdx_o,
    output logic                              done_o,
    output logic                              busy_o,
    output logic                              overrun_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]  capData   [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  shiftData [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] capValid;
    logic                   full;
    logic                   transfer;

    assign full     = &capValid;
    // The full capture bank is moved to the shift bank only while nothing is
    // draining. During SHIFT a full bank waits for the current frame to end.
    assign transfer = (state == IDLE) && full;

    function automatic logic [DATA_WIDTH-1:0] outWord(input logic [DATA_WIDTH-1:0] word);
`ifdef LAYER_SERIALIZER_RELU_EN
        return word[DATA_WIDTH-1] ? '0 : word;
`else
        return word;
`endif
    endfunction

    // Data banks. A word is stored in a slot only if the slot is empty, or if
    // this edge is a transfer edge. On a transfer edge every slot is released
    // and an arrival on that edge starts the next frame.
    // NOTE: the data arrays have no reset. The capValid flags (which are reset)
    // decide whether a slot holds a valid word, so clearing the data is not needed.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NUM_NEURONS; j++) begin
            if (neuronValid_i[j] && (transfer || !capValid[j])) begin
                capData[j] <= neuronOut_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (transfer) begin
            shiftData <= capData;
        end
    end

    // Control: capture flags, overrun flag, and the IDLE/SHIFT sequencer with
    // registered outputs.
    // NOTE: this block holds state, so it uses only non-blocking assignments. Every
    // register then reads the pre-edge values of the other registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            counter     <= '0;
            capValid    <= '0;
            out_o       <= '0;
            outValid_or <= 1'b0;
            outIdx_o    <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (transfer) begin
                capValid <= neuronValid_i;
            end else begin
                capValid <= capValid | neuronValid_i;
                // A second pulse into a slot that is already filled is dropped.
                if (|(neuronValid_i & capValid)) begin
                    overrun_o <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (full) begin
                        out_o       <= outWord(capData[0]);
                        outValid_or <= 1'b1;
                        outIdx_o    <= '0;
                        done_o      <= 1'b0;
                        busy_o      <= 1'b1;
                        counter     <= IDX_WIDTH'(1);
                        state       <= SHIFT;
                    end else begin
                        outValid_or <= 1'b0;
                        done_o      <= 1'b0;
                    end
                end

                SHIFT: begin
                    out_o       <= outWord(shiftData[counter]);
                    outIdx_o    <= counter;
                    outValid_or <= 1'b1;
                    if (counter == LAST_IDX) begin
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        done_o  <= 1'b0;
                        counter <= counter + IDX_WIDTH'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// -----------------------------------------------------------------------------
// tb_layer_serializer
//
// Testbench for layer_serializer with NUM_NEURONS=4 and DATA_WIDTH=16. The
// stimulus pushes the expected words into a scoreboard queue. A monitor on the
// falling clock edge pops one entry and compares it each time the DUT shows a
// valid word. The stimulus code also checks latency, flags and reset behaviour.
// -----------------------------------------------------------------------------
module tb_layer_serializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          done;
        logic          contig;  // previous cycle must also have been valid
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N*DW-1:0]   neuronOut_i = '0;
    logic [N-1:0]      neuronValid_i = '0;
    logic [DW-1:0]     out_o;
    logic              outValid_or;
    logic [IW-1:0]     outIdx_o;
    logic              done_o;
    logic              busy_o;
    logic              overrun_o;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic lastValid  = 1'b0;

    layer_serializer #(
        .NUM_NEURONS(N),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .neuronOut_i  (neuronOut_i),
        .neuronValid_i(neuronValid_i),
        .out_o        (out_o),
        .outValid_or  (outValid_or),
        .outIdx_o     (outIdx_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // The value expected on out_o for a captured word.
    function automatic logic [DW-1:0] ew(input logic [DW-1:0] w);
`ifdef LAYER_SERIALIZER_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Pushes a whole frame. If contig0 is set, word 0 must follow the previous
    // frame with no gap.
    task automatic pushFrame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                             input logic contig0);
        expQ.push_back('{ew(w0), 2'd0, 1'b0, contig0});
        expQ.push_back('{ew(w1), 2'd1, 1'b0, 1'b1});
        expQ.push_back('{ew(w2), 2'd2, 1'b0, 1'b1});
        expQ.push_back('{ew(w3), 2'd3, 1'b1, 1'b1});
    endtask

    // Drives valid pulses for one edge. The task starts and ends 1 time unit
    // after a rising edge.
    task automatic pulse(input logic [N-1:0] mask,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        neuronValid_i = mask;
        neuronOut_i   = {w3, w2, w1, w0};
        @(posedge clk_i);
        #1;
        neuronValid_i = '0;
        neuronOut_i   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (outValid_or) begin
            if (expQ.size() == 0) begin
                check("unexpected_word_idx", 32'(outIdx_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("sb_data", 32'(out_o), 32'(e.data));
                check("sb_idx",  32'(outIdx_o), 32'(e.idx));
                check("sb_done", 32'(done_o), 32'(e.done));
                if (e.contig) check("sb_no_gap", 32'(lastValid), 32'd1);
            end
        end
        lastValid = outValid_or;
    end

    initial begin
        // Reset
        rst_ni = 1'b0;
        idle(3);
        @(negedge clk_i);
        check("rst_valid",   32'(outValid_or), 32'd0);
        check("rst_out",     32'(out_o), 32'd0);
        check("rst_idx",     32'(outIdx_o), 32'd0);
        check("rst_done",    32'(done_o), 32'd0);
        check("rst_busy",    32'(busy_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(1);

        // Single frame: all valids on one edge
        pushFrame(16'd10, -16'sd3, 16'd7, 16'h7FFF, 1'b0);
        pulse(4'b1111, 16'd10, -16'sd3, 16'd7, 16'h7FFF);
        @(negedge clk_i);
        check("single_no_early_out", 32'(outValid_or), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("single_word0_valid", 32'(outValid_or), 32'd1);
        check("single_busy",        32'(busy_o), 32'd1);
        #6;
        idle(5);
        check("single_after_valid", 32'(outValid_or), 32'd0);
        check("single_after_busy",  32'(busy_o), 32'd0);

        // Staggered arrival: valids in order 3, 1, 0, 2
        pulse(4'b1000, 16'd0, 16'd0, 16'd0, -16'sd400);
        idle(1);
        pulse(4'b0010, 16'd0, -16'sd200, 16'd0, 16'd0);
        pulse(4'b0001, 16'd100, 16'd0, 16'd0, 16'd0);
        idle(1);
        check("stag_nothing_yet", 32'(outValid_or), 32'd0);
        pushFrame(16'd100, -16'sd200, 16'd300, -16'sd400, 1'b0);
        pulse(4'b0100, 16'd0, 16'd0, 16'd300, 16'd0);
        @(negedge clk_i);
        check("stag_no_early_out", 32'(outValid_or), 32'd0);
        #6;
        idle(6);

        // Back-to-back: frame B fills while frame A shifts
        pushFrame(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        pushFrame(16'd21, 16'd22, 16'd23, 16'd24, 1'b1);
        pulse(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
        idle(1);
        pulse(4'b1111, 16'd21, 16'd22, 16'd23, 16'd24);
        idle(8);
        check("b2b_no_overrun", 32'(overrun_o), 32'd0);

        // Capture on the transfer edge: neuron 0 of the next frame arrives
        // on that edge
        pushFrame(16'd31, 16'd32, 16'd33, 16'd34, 1'b0);
        pushFrame(16'd55, 16'd56, 16'd57, 16'd58, 1'b1);
        pulse(4'b1111, 16'd31, 16'd32, 16'd33, 16'd34);
        pulse(4'b0001, 16'd55, 16'd0, 16'd0, 16'd0);
        check("xfer_edge_no_overrun", 32'(overrun_o), 32'd0);
        pulse(4'b1110, 16'd0, 16'd56, 16'd57, 16'd58);
        idle(8);
        check("xfer_edge_still_clean", 32'(overrun_o), 32'd0);

        // Overrun: neuron 1 pulses twice before the bank is full
        pushFrame(16'd1, 16'd5, 16'd2, 16'hFFFF, 1'b0);
        pulse(4'b0010, 16'd0, 16'd5, 16'd0, 16'd0);
        pulse(4'b0010, 16'd0, 16'd9, 16'd0, 16'd0);
        @(negedge clk_i);
        check("overrun_set", 32'(overrun_o), 32'd1);
        #6;
        pulse(4'b1101, 16'd1, 16'd0, 16'd2, 16'hFFFF);
        idle(6);
        check("overrun_sticky", 32'(overrun_o), 32'd1);

        // Reset mid-SHIFT, with one partial capture that reset must discard
        expQ.push_back('{ew(16'd11), 2'd0, 1'b0, 1'b0});
        expQ.push_back('{ew(16'd12), 2'd1, 1'b0, 1'b1});
        pulse(4'b1111, 16'd11, 16'd12, 16'd13, 16'd14);
        idle(1);                                       // word 0 on out_o
        pulse(4'b0001, 16'd77, 16'd0, 16'd0, 16'd0);   // word 1 on out_o
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rstmid_valid",   32'(outValid_or), 32'd0);
        check("rstmid_overrun", 32'(overrun_o), 32'd0);
        check("rstmid_busy",    32'(busy_o), 32'd0);
        #6;
        rst_ni = 1'b1;
        idle(1);
        // Neuron 0's earlier capture was cleared, so this frame stays incomplete
        pulse(4'b1110, 16'd0, 16'd62, 16'd63, 16'd64);
        idle(6);
        check("rstmid_no_words", 32'(outValid_or), 32'd0);
        pushFrame(16'd61, 16'd62, 16'd63, 16'd64, 1'b0);
        pulse(4'b0001, 16'd61, 16'd0, 16'd0, 16'd0);
        idle(7);

        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Collects the parallel `out_o` / `outValid_or` results of one layer's `Neuron` instances and replays them one word per cycle as the `myInput_i` / `myInputValid_i` stream of the next layer. It sits between two layers and is double-buffered: a capture bank fills while a shift bank drains, so layer N+1 streaming overlaps layer N computing the next sample. Outputs are emitted in neuron-index order, 0 first.

## Interface
- `NUM_NEURONS`, default 30: neurons in the upstream layer (≥2).
- `DATA_WIDTH`, default 16: width of each neuron output word, signed two's complement.
- `IDX_WIDTH`, default `$clog2(NUM_NEURONS)`: width of the index counter.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `neuronOut_i` input NUM_NEURONS*DATA_WIDTH: neuron j's word is at bits `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `neuronValid_i` input NUM_NEURONS: bit j is neuron j's `outValid_or` (single-cycle pulse).
- `out_o` output DATA_WIDTH: serialized word, registered.
- `outValid_or` output 1: `out_o` is valid this cycle; drives the next layer's `myInputValid_i`.
- `outIdx_o` output IDX_WIDTH: index of the neuron whose word is on `out_o`.
- `done_o` output 1: high with the last word of a frame (index NUM_NEURONS-1).
- `busy_o` output 1: shift bank is draining (state SHIFT).
- `overrun_o` output 1: sticky; a neuron word was dropped.

## Operation
- **Capture bank:** `capData[j]` and `capValid[j]`.
  - When `neuronValid_i[j]=1` and `capValid[j]=0`, latch the word and set `capValid[j]`.
  - `full` means all bits of `capValid` are 1.
- **Overrun:** when `neuronValid_i[j]=1` and `capValid[j]=1`, outside a transfer edge:
  - the word is dropped and the existing `capData[j]` is kept;
  - `overrun_o` is set to 1 and is cleared only by reset.
- **States:**
  - IDLE: `busy_o=0`.
  - SHIFT: `busy_o=1`.
- **Transfer edge:** state is IDLE and `full=1`. On this edge:
  - shift bank ← `capData`;
  - `out_o` ← `capData[0]` (through the ReLU if enabled), `outValid_or`←1, `outIdx_o`←0, `done_o`←0;
  - state ← SHIFT, read counter ← 1;
  - `capValid` ← `neuronValid_i`, and the words of the new arrivals are latched. Arrivals on this edge start the next frame and are not overruns.
- **In SHIFT, each edge:**
  - `out_o` ← shift bank[counter], `outIdx_o` ← counter, `outValid_or` ← 1, counter++.
  - When counter = NUM_NEURONS-1: `done_o` ← 1 and state ← IDLE.
- **In IDLE without `full`:** `outValid_or` ← 0 and `done_o` ← 0. `out_o` and `outIdx_o` hold their values.
- **Capture during SHIFT:** the capture bank keeps filling independently of the shift bank.
- **Arithmetic:** no truncation or saturation is performed. Words pass through at DATA_WIDTH.

## Timing
- **Reset values:** `out_o`=0, `outValid_or`=0, `outIdx_o`=0, `done_o`=0, `busy_o`=0, `overrun_o`=0. State is IDLE, all `capValid` bits are 0, counter is 0.
- **Latency:** if the last missing capture is sampled at edge E with the block in IDLE:
  - the transfer happens at edge E+1;
  - word k is visible in the cycle after edge E+1+k;
  - `done_o` coincides with word NUM_NEURONS-1.
- **Back-to-back frames:** if the capture bank is full when `done_o` is issued, the next transfer occurs on the following edge. `outValid_or` stays high with zero gap.
- **Frame length:** `outValid_or` is high for exactly NUM_NEURONS consecutive cycles per frame. The block has no backpressure; the next layer must accept every cycle.
- **Reset mid-SHIFT:** on the reset edge all state clears. `outValid_or` is 0 in the cycle after that edge, and partially captured data is discarded.
- **Reset dominance:** reset overrides every simultaneous valid or transfer.

## Configuration
- `LAYER_SERIALIZER_RELU_EN` defined:
  - the word driven onto `out_o` passes through ReLU: if the MSB is 1, `out_o` ← 0, else the word is passed unchanged;
  - `capData` is unaffected.
- Undefined: words pass through unmodified, and signed negative values appear on `out_o`.

## Test plan
- **Single frame:** NUM_NEURONS=4, all valid bits pulsed on one edge with words 10, -3, 7, 0x7FFF.
  - `out_o` = 10, -3, 7, 0x7FFF (-3 becomes 0 with RELU_EN) on 4 consecutive cycles starting 2 edges after the pulse.
  - `outIdx_o` = 0..3; `done_o` high only with 0x7FFF.
- **Staggered arrival:** valids in order 3, 1, 0, 2 on separate cycles.
  - No output until neuron 2 is captured, then words appear in index order 0..3 exactly one edge later.
- **Back-to-back:** the second frame becomes full while the first is shifting.
  - `outValid_or` is continuous for 8 cycles; the second frame's index 0 follows the first frame's `done_o` with no gap.
- **Overrun:** `neuronValid_i[1]` pulses twice (words 5, then 9) before the bank is full.
  - `overrun_o`=1 and stays 1; the emitted word 1 is 5.
- **Reset mid-SHIFT:** `rst_ni`=0 on the edge after word 1 is output.
  - `outValid_or`=0 in the cycle after the reset edge; no further words appear; `overrun_o`=0.
- **Capture at the transfer edge:** a valid arrives for neuron 0 on the transfer edge.
  - No overrun; it becomes word 0 of the next frame.
